// File: rtl/pipe_beat_deser.sv
// pipe_beat_deser
// Receive side of the narrow beat link for method pipes. Beats of BEAT bits
// are collected into one WIDTH-bit message and offered to a PipeIn-style
// consumer. Frames that end early (short) or run past NBEATS beats (long)
// are dropped and reported as framing errors.
//
// Ports
//   CLK         rising-edge clock
//   RST         asynchronous active-high reset
//   beat_valid  link beat present
//   beat_data   beat payload (BEAT bits)
//   beat_last   final beat of a frame
//   beat_ready  registered beat accept
//   enq_valid   assembled message available
//   enq_data    assembled message (WIDTH bits)
//   enq_ready   consumer accepts the message
//   err_pulse   one-cycle pulse per framing error
//   msg_count   delivered messages, wraps at 2^16
//   err_count   framing errors, saturates at 255
module pipe_beat_deser #(
  parameter int WIDTH = 96,
  parameter int BEAT  = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             beat_valid,
  input  logic [BEAT-1:0]  beat_data,
  input  logic             beat_last,
  output logic             beat_ready,
  output logic             enq_valid,
  output logic [WIDTH-1:0] enq_data,
  input  logic             enq_ready,
  output logic             err_pulse,
  output logic [15:0]      msg_count,
  output logic [7:0]       err_count
);

  localparam int NBEATS = WIDTH / BEAT;
  localparam int IDXW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBEATS - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FULL    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             beat_ready_q, beat_ready_d;
  logic             enq_valid_q, enq_valid_d;
  logic [WIDTH-1:0] enq_data_q, enq_data_d;
  logic             err_pulse_q, err_pulse_d;
  logic [15:0]      msg_count_q, msg_count_d;
  logic [7:0]       err_count_q, err_count_d;

  logic beat_fire_s;
  logic enq_fire_s;
  logic idx_last_s;

  // Handshake decodes; beat_ready_q is already low in FULL, so no state gating needed.
  assign beat_fire_s = beat_valid && beat_ready_q;
  assign enq_fire_s  = enq_valid_q && enq_ready;
  assign idx_last_s  = (idx_q == IDX_LAST);

  // State and beat-index register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_COLLECT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: framing decisions on each accepted beat.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_COLLECT: begin
        if (beat_fire_s) begin
          if (idx_last_s) begin
            // Last slot filled: good frame if marked last, else it overruns.
            state_d = beat_last ? ST_FULL : ST_DISCARD;
            idx_d   = '0;
          end else if (beat_last) begin
            // Short frame: restart assembly in place.
            state_d = ST_COLLECT;
            idx_d   = '0;
          end else begin
            state_d = ST_COLLECT;
            idx_d   = idx_q + IDXW'(1);
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_FULL: begin
        if (enq_fire_s) begin
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_FULL;
        end
      end
      ST_DISCARD: begin
        if (beat_fire_s && beat_last) begin
          state_d = ST_COLLECT;
          idx_d   = '0;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        idx_d   = '0;
      end
    endcase
  end

  // Output next-values: handshakes follow the next state so they are registered.
  always_comb begin
    beat_ready_d = (state_d != ST_FULL);
    enq_valid_d  = (state_d == ST_FULL);
    err_pulse_d  = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (beat_fire_s) begin
          err_pulse_d = (idx_last_s != beat_last);
        end else begin
          err_pulse_d = 1'b0;
        end
      end
      default: begin
        err_pulse_d = 1'b0;
      end
    endcase

    if (enq_fire_s) begin
      msg_count_d = msg_count_q + 16'd1;
    end else begin
      msg_count_d = msg_count_q;
    end

    if (err_pulse_d && (err_count_q != 8'd255)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Payload slot write; slots are never cleared, enq_valid qualifies them.
  always_comb begin
    enq_data_d = enq_data_q;
    for (int b = 0; b < NBEATS; b++) begin
      if ((state_q == ST_COLLECT) && beat_fire_s && (idx_q == IDXW'(b))) begin
        enq_data_d[b*BEAT +: BEAT] = beat_data;
      end else begin
        enq_data_d[b*BEAT +: BEAT] = enq_data_q[b*BEAT +: BEAT];
      end
    end
  end

  // Output and counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      beat_ready_q <= 1'b0;
      enq_valid_q  <= 1'b0;
      enq_data_q   <= '0;
      err_pulse_q  <= 1'b0;
      msg_count_q  <= 16'd0;
      err_count_q  <= 8'd0;
    end else begin
      beat_ready_q <= beat_ready_d;
      enq_valid_q  <= enq_valid_d;
      enq_data_q   <= enq_data_d;
      err_pulse_q  <= err_pulse_d;
      msg_count_q  <= msg_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign beat_ready = beat_ready_q;
  assign enq_valid  = enq_valid_q;
  assign enq_data   = enq_data_q;
  assign err_pulse  = err_pulse_q;
  assign msg_count  = msg_count_q;
  assign err_count  = err_count_q;

endmodule

// File: doc/pipe_beat_deser.md
# pipe_beat_deser

Receive side of the narrow-link transport for method pipes. It reassembles fixed-count beats from a narrow beat link into one wide pipe message and presents it to a downstream PipeIn-style consumer (for example a request or indication input adapter). It detects framing errors and discards corrupt frames. It pairs with a beat serializer at the far end of the link.

## Interface
- WIDTH, 96: pipe message width in bits; must be a multiple of BEAT.
- BEAT, 32: link beat width in bits. NBEATS = WIDTH/BEAT, which is 3 at the defaults.
- CLK  in  1  rising-edge clock for all state.
- RST  in  1  reset, asynchronous, active-high. All registers clear on assertion.
- beat_valid  in  1  link beat present.
- beat_data  in  BEAT  beat payload.
- beat_last  in  1  marks the final beat of a frame.
- beat_ready  out  1  deser accepts a beat this cycle (registered).
- enq_valid  out  1  assembled message available.
- enq_data  out  WIDTH  assembled message.
- enq_ready  in  1  consumer accepts the message.
- err_pulse  out  1  one-cycle pulse per framing error.
- msg_count  out  16  messages delivered; wraps modulo 2^16.
- err_count  out  8  framing errors; saturates at 255.

## Operation
- Beat transfer when beat_valid && beat_ready. Message transfer when enq_valid && enq_ready.
- State COLLECT, beat index idx in 0..NBEATS-1:
  - Each accepted beat writes enq_data[BEAT*idx +: BEAT].
  - beat_last=1 with idx<NBEATS-1 (short frame): drop the partial message, set idx=0, pulse err_pulse, stay in COLLECT.
  - beat_last=0 with idx=NBEATS-1 (long frame): drop the message, pulse err_pulse, go to DISCARD.
  - beat_last=1 with idx=NBEATS-1: good frame. Go to FULL, set idx=0.
  - Otherwise, idx increments.
- State FULL:
  - enq_valid=1 and enq_data is held stable.
  - beat_ready=0.
  - On message transfer, msg_count increments and the state returns to COLLECT.
- State DISCARD:
  - beat_ready=1 and beats are consumed without being stored.
  - The beat with beat_last=1 returns the state to COLLECT with idx=0. It does not pulse an error.
- err_count increments on every err_pulse and holds at 255.
- enq_data bits are not cleared between messages. Only enq_valid qualifies them.

## Timing
- Reset values:
  - State COLLECT, idx=0.
  - beat_ready=0, enq_valid=0, enq_data=0, err_pulse=0, msg_count=0, err_count=0.
- beat_ready is registered:
  - It is 1 from the first CLK edge after RST deasserts while the state is COLLECT or DISCARD.
  - It is 0 in the cycle after the last-beat transfer of a good frame, and stays 0 through FULL.
  - It is 1 again in the cycle after the message transfer.
- Latency: enq_valid rises in the cycle following the edge that accepted the final beat.
- Minimum message period is NBEATS+1 cycles (4 at the defaults). There is no bypass of the FULL stage.
- enq_ready is ignored outside FULL. enq_valid never depends combinationally on enq_ready.
- err_pulse is asserted in the cycle after the offending beat transfer.
- beat_valid with beat_ready=0 has no effect. The upstream side holds the beat.
- RST asserted mid-frame or in FULL: the partial or held message is lost immediately and no error is counted.

## Test plan
- Good frame: beats 0x11111111, 0x22222222, 0x33333333 (last on the third), enq_ready=1 -> enq_data=0x333333332222222211111111, enq_valid for exactly 1 cycle, msg_count=1.
- Backpressure: good frame with enq_ready=0 for 5 cycles -> enq_valid and enq_data stable, beat_ready=0 throughout, a next frame offered by the upstream side is not accepted until the cycle after enq_ready=1.
- Short frame: 2 beats with last on the second, then a good frame -> err_pulse once, err_count=1, only the second frame is delivered with correct data.
- Long frame: 5 beats with last on the fifth, then a good frame -> one err_pulse, beats 4–5 discarded, the good frame is delivered, msg_count=1.
- Reset mid-frame: RST pulsed after beat 2 -> all outputs at reset values, beat_ready=0 during reset; the next 3-beat frame is delivered intact.
- Counters: 65537 good frames -> msg_count=1; 300 short frames -> err_count=255.
